// File: rtl/video_source_sequencer.sv
// Frame-aligned switch between NUM_SRC pixel sources sharing one display sink.
// Optional VIDEO_SWITCH_BLANK_EN blanks line 0 of the first frame after a switch.
module video_source_sequencer #(
  parameter int NUM_SRC        = 4,
  parameter int H_WORDS        = 80,
  parameter int V_LINES        = 500,
  parameter int FRAMES_PER_SRC = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   VideoReady,
  input  logic [24*NUM_SRC-1:0]  SrcVideo,
  output logic [NUM_SRC-1:0]     SrcReady,
  output logic [NUM_SRC-1:0]     SrcRestart,
  output logic [23:0]            video,
  input  logic [1:0]             SelReq,
  input  logic                   SelReqValid,
  input  logic                   AutoCycle,
  output logic [1:0]             ActiveSrc,
  output logic                   SwitchPending,
  output logic                   FrameDone
);

  localparam int HW   = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;
  localparam int VW   = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int FW   = $clog2(FRAMES_PER_SRC + 1);
  localparam logic [2:0] NUM_SRC_L  = 3'(NUM_SRC);
  localparam logic [1:0] LAST_SRC   = 2'(NUM_SRC - 1);
  localparam logic [HW-1:0] H_LAST  = HW'(H_WORDS - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_LINES - 1);
  localparam logic [FW-1:0] F_LAST  = FW'(FRAMES_PER_SRC - 1);

  typedef enum logic {RUN, PEND} state_t;

  state_t            state, state_nxt;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [FW-1:0]     frame_cnt;
  logic [1:0]        pend_sel, pend_nxt, active_nxt, auto_next;
  logic [NUM_SRC-1:0] restart_nxt;
  logic              last_beat, req_ok, auto_due, switch_now;
  logic [23:0]       src_pix;

  assign last_beat     = VideoReady && (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign req_ok        = SelReqValid && ({1'b0, SelReq} < NUM_SRC_L);
  assign auto_due      = AutoCycle && (frame_cnt == F_LAST);
  assign auto_next     = (ActiveSrc == LAST_SRC) ? 2'd0 : ActiveSrc + 2'd1;
  assign SwitchPending = (state == PEND);

  always_comb begin
    src_pix  = SrcVideo[23:0];
    SrcReady = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ActiveSrc == 2'(i)) begin
        src_pix     = SrcVideo[24*i +: 24];
        SrcReady[i] = VideoReady;
      end
    end
  end

  // A request strobed on the last beat is latched but never applied at that
  // same boundary; only an already-pending request switches there.
  always_comb begin
    state_nxt  = state;
    pend_nxt   = pend_sel;
    active_nxt = ActiveSrc;
    switch_now = 1'b0;
    case (state)
      RUN: begin
        if (last_beat && auto_due) begin
          active_nxt = auto_next;
          switch_now = 1'b1;
        end
        if (req_ok && (SelReq != ActiveSrc)) begin
          pend_nxt  = SelReq;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (last_beat) begin
          active_nxt = pend_sel;
          switch_now = 1'b1;
          state_nxt  = RUN;
          if (req_ok && (SelReq != pend_sel)) begin
            pend_nxt  = SelReq;
            state_nxt = PEND;
          end
        end else if (req_ok) begin
          if (SelReq == ActiveSrc) state_nxt = RUN;
          else                     pend_nxt  = SelReq;
        end
      end
      default: state_nxt = RUN;
    endcase
    restart_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++)
      restart_nxt[i] = switch_now && (active_nxt == 2'(i));
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= RUN;
      pend_sel   <= 2'd0;
      ActiveSrc  <= 2'd0;
      SrcRestart <= '0;
      FrameDone  <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_sel   <= pend_nxt;
      ActiveSrc  <= active_nxt;
      SrcRestart <= restart_nxt;
      FrameDone  <= last_beat;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (VideoReady) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || !AutoCycle || switch_now) frame_cnt <= '0;
    else if (last_beat)                    frame_cnt <= frame_cnt + 1'b1;
  end

`ifdef VIDEO_SWITCH_BLANK_EN
  // Set on a switch (counters are at origin then); cleared once line 0 is done.
  logic blank_r;
  always_ff @(posedge Clock) begin
    if (Reset)              blank_r <= 1'b0;
    else if (switch_now)    blank_r <= 1'b1;
    else if (v_cnt != '0)   blank_r <= 1'b0;
  end
  assign video = (blank_r && (v_cnt == '0)) ? 24'h000000 : src_pix;
`else
  assign video = src_pix;
`endif

endmodule

// File: tb/tb_video_source_sequencer.sv
// Directed bench for video_source_sequencer with a 4x3 frame and 2 frames per source.
module tb_video_source_sequencer;

  localparam logic [23:0] S0 = 24'h1ABC9C;
  localparam logic [23:0] S1 = 24'h10F00F;
  localparam logic [23:0] S2 = 24'h2C2C2C;
  localparam logic [23:0] S3 = 24'h3D3D3D;
`ifdef VIDEO_SWITCH_BLANK_EN
  localparam logic BLANK = 1'b1;
`else
  localparam logic BLANK = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset, VideoReady, SelReqValid, AutoCycle;
  logic [1:0]  SelReq;
  logic [95:0] src_video4;
  logic [71:0] src_video3;
  logic [3:0]  src_ready, src_restart;
  logic [2:0]  src_ready3, src_restart3;
  logic [23:0] video, video3;
  logic [1:0]  active_src, active_src3;
  logic        switch_pending, switch_pending3, frame_done, frame_done3;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 Clock = ~Clock;

  video_source_sequencer #(.NUM_SRC(4), .H_WORDS(4), .V_LINES(3), .FRAMES_PER_SRC(2)) dut (
    .Clock(Clock), .Reset(Reset), .VideoReady(VideoReady), .SrcVideo(src_video4),
    .SrcReady(src_ready), .SrcRestart(src_restart), .video(video),
    .SelReq(SelReq), .SelReqValid(SelReqValid), .AutoCycle(AutoCycle),
    .ActiveSrc(active_src), .SwitchPending(switch_pending), .FrameDone(frame_done));

  video_source_sequencer #(.NUM_SRC(3), .H_WORDS(4), .V_LINES(3), .FRAMES_PER_SRC(2)) dut3 (
    .Clock(Clock), .Reset(Reset), .VideoReady(VideoReady), .SrcVideo(src_video3),
    .SrcReady(src_ready3), .SrcRestart(src_restart3), .video(video3),
    .SelReq(SelReq), .SelReqValid(SelReqValid), .AutoCycle(AutoCycle),
    .ActiveSrc(active_src3), .SwitchPending(switch_pending3), .FrameDone(frame_done3));

  // Advance one clock; inputs change and outputs are sampled 1-2 time units after the edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; VideoReady = 1'b0; SelReqValid = 1'b0; SelReq = 2'd0; AutoCycle = 1'b0;
    step(); step();
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++; if (active_src !== 2'd0) $display("FAIL reset_active got %0d exp 0", active_src); else pass_cnt++;
    chk_cnt++; if (switch_pending !== 1'b0) $display("FAIL reset_pending got %b exp 0", switch_pending); else pass_cnt++;
    chk_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b exp 0", frame_done); else pass_cnt++;
    chk_cnt++; if (src_restart !== 4'b0000) $display("FAIL reset_restart got %b exp 0000", src_restart); else pass_cnt++;
    chk_cnt++; if (src_ready !== 4'b0000) $display("FAIL reset_ready got %b exp 0000", src_ready); else pass_cnt++;
  endtask

  task automatic test_first_frame();
    int fd_seen;
    do_reset();
    fd_seen = 0;
    VideoReady = 1'b1;
    for (int b = 1; b <= 12; b++) begin
      #1;
      chk_cnt++; if (video !== S0) $display("FAIL ff_video beat %0d got %h exp %h", b, video, S0); else pass_cnt++;
      chk_cnt++; if (src_ready !== 4'b0001) $display("FAIL ff_ready beat %0d got %b exp 0001", b, src_ready); else pass_cnt++;
      if (frame_done) fd_seen++;
      step();
    end
    VideoReady = 1'b0;
    #1;
    chk_cnt++; if (fd_seen !== 0) $display("FAIL ff_early_done got %0d pulses exp 0", fd_seen); else pass_cnt++;
    chk_cnt++; if (frame_done !== 1'b1) $display("FAIL ff_done_cycle13 got %b exp 1", frame_done); else pass_cnt++;
    chk_cnt++; if (active_src !== 2'd0) $display("FAIL ff_active got %0d exp 0", active_src); else pass_cnt++;
    step();
    chk_cnt++; if (frame_done !== 1'b0) $display("FAIL ff_done_single got %b exp 0", frame_done); else pass_cnt++;
  endtask

  task automatic test_manual_switch();
    do_reset();
    VideoReady = 1'b1; SelReq = 2'd2;
    for (int b = 1; b <= 12; b++) begin
      SelReqValid = (b == 3);
      #1;
      if (b == 4 || b == 12) begin
        chk_cnt++; if (switch_pending !== 1'b1) $display("FAIL ms_pending beat %0d got %b exp 1", b, switch_pending); else pass_cnt++;
        chk_cnt++; if (active_src !== 2'd0) $display("FAIL ms_active_hold beat %0d got %0d exp 0", b, active_src); else pass_cnt++;
      end
      step();
    end
    SelReqValid = 1'b0;
    #1;
    chk_cnt++; if (active_src !== 2'd2) $display("FAIL ms_active got %0d exp 2", active_src); else pass_cnt++;
    chk_cnt++; if (src_restart !== 4'b0100) $display("FAIL ms_restart got %b exp 0100", src_restart); else pass_cnt++;
    chk_cnt++; if (switch_pending !== 1'b0) $display("FAIL ms_pending_clr got %b exp 0", switch_pending); else pass_cnt++;
    chk_cnt++; if (frame_done !== 1'b1) $display("FAIL ms_frame_done got %b exp 1", frame_done); else pass_cnt++;
    chk_cnt++; if (src_ready !== 4'b0100) $display("FAIL ms_ready got %b exp 0100", src_ready); else pass_cnt++;
    chk_cnt++; if (video !== (BLANK ? 24'h0 : S2)) $display("FAIL ms_video got %h exp %h", video, BLANK ? 24'h0 : S2); else pass_cnt++;
    step();
    chk_cnt++; if (src_restart !== 4'b0000) $display("FAIL ms_restart_pulse got %b exp 0000", src_restart); else pass_cnt++;
    chk_cnt++; if (src_ready !== 4'b0100) $display("FAIL ms_ready2 got %b exp 0100", src_ready); else pass_cnt++;
  endtask

  task automatic test_cancel();
    do_reset();
    VideoReady = 1'b1;
    for (int b = 1; b <= 12; b++) begin
      SelReqValid = (b == 3) || (b == 6);
      SelReq = (b == 6) ? 2'd0 : 2'd2;
      #1;
      if (b == 5) begin
        chk_cnt++; if (switch_pending !== 1'b1) $display("FAIL cn_pending got %b exp 1", switch_pending); else pass_cnt++;
      end
      if (b == 7) begin
        chk_cnt++; if (switch_pending !== 1'b0) $display("FAIL cn_cancel got %b exp 0", switch_pending); else pass_cnt++;
      end
      step();
    end
    SelReqValid = 1'b0;
    #1;
    chk_cnt++; if (active_src !== 2'd0) $display("FAIL cn_active got %0d exp 0", active_src); else pass_cnt++;
    chk_cnt++; if (src_restart !== 4'b0000) $display("FAIL cn_restart got %b exp 0000", src_restart); else pass_cnt++;
  endtask

  task automatic test_last_beat_request();
    do_reset();
    VideoReady = 1'b1; SelReq = 2'd1;
    for (int b = 1; b <= 12; b++) begin
      SelReqValid = (b == 12);
      #1;
      step();
    end
    SelReqValid = 1'b0;
    #1;
    chk_cnt++; if (active_src !== 2'd0) $display("FAIL lb_active_boundary got %0d exp 0", active_src); else pass_cnt++;
    chk_cnt++; if (src_restart !== 4'b0000) $display("FAIL lb_restart_boundary got %b exp 0000", src_restart); else pass_cnt++;
    chk_cnt++; if (switch_pending !== 1'b1) $display("FAIL lb_latched got %b exp 1", switch_pending); else pass_cnt++;
    for (int b = 1; b <= 12; b++) begin
      #1;
      if (b == 6 || b == 12) begin
        chk_cnt++; if (active_src !== 2'd0) $display("FAIL lb_active_frame2 beat %0d got %0d exp 0", b, active_src); else pass_cnt++;
      end
      step();
    end
    #1;
    chk_cnt++; if (active_src !== 2'd1) $display("FAIL lb_active_switch got %0d exp 1", active_src); else pass_cnt++;
    chk_cnt++; if (src_restart !== 4'b0010) $display("FAIL lb_restart got %b exp 0010", src_restart); else pass_cnt++;
  endtask

  task automatic test_invalid_sel();
    do_reset();
    VideoReady = 1'b1; SelReq = 2'd3;
    for (int b = 1; b <= 12; b++) begin
      SelReqValid = (b == 3);
      #1;
      if (b == 4) begin
        chk_cnt++; if (switch_pending3 !== 1'b0) $display("FAIL iv_pending3 got %b exp 0", switch_pending3); else pass_cnt++;
        chk_cnt++; if (switch_pending !== 1'b1) $display("FAIL iv_pending4 got %b exp 1", switch_pending); else pass_cnt++;
        chk_cnt++; if (src_ready3 !== 3'b001) $display("FAIL iv_ready3 got %b exp 001", src_ready3); else pass_cnt++;
      end
      step();
    end
    SelReqValid = 1'b0;
    #1;
    chk_cnt++; if (active_src3 !== 2'd0) $display("FAIL iv_active3 got %0d exp 0", active_src3); else pass_cnt++;
    chk_cnt++; if (src_restart3 !== 3'b000) $display("FAIL iv_restart3 got %b exp 000", src_restart3); else pass_cnt++;
    chk_cnt++; if (active_src !== 2'd3) $display("FAIL iv_active4 got %0d exp 3", active_src); else pass_cnt++;
  endtask

  task automatic test_auto_cycle();
    logic [1:0] exp_a;
    logic [3:0] exp_r;
    int beats;
    do_reset();
    AutoCycle = 1'b1; VideoReady = 1'b1;
    for (int k = 0; k <= 96; k++) begin
      #1;
      exp_a = 2'((k / 24) % 4);
      chk_cnt++; if (active_src !== exp_a) $display("FAIL ac_active beat %0d got %0d exp %0d", k, active_src, exp_a); else pass_cnt++;
      step();
    end
    do_reset();
    AutoCycle = 1'b1;
    for (int c = 0; c <= 120; c++) begin
      VideoReady = (c % 2 == 0);
      #1;
      beats = (c + 1) / 2;
      exp_a = 2'((beats / 24) % 4);
      exp_r = VideoReady ? (4'b0001 << exp_a) : 4'b0000;
      chk_cnt++; if (active_src !== exp_a) $display("FAIL ac_toggle_active cyc %0d got %0d exp %0d", c, active_src, exp_a); else pass_cnt++;
      if (c % 10 == 0 || c % 10 == 1) begin
        chk_cnt++; if (src_ready !== exp_r) $display("FAIL ac_toggle_ready cyc %0d got %b exp %b", c, src_ready, exp_r); else pass_cnt++;
      end
      step();
    end
    AutoCycle = 1'b0;
  endtask

  task automatic test_blank();
    logic [23:0] exp_v;
    do_reset();
    VideoReady = 1'b1; SelReq = 2'd1;
    for (int b = 1; b <= 12; b++) begin
      SelReqValid = (b == 2);
      #1;
      step();
    end
    SelReqValid = 1'b0;
    for (int b = 1; b <= 12; b++) begin
      #1;
      exp_v = (BLANK && b <= 4) ? 24'h000000 : S1;
      chk_cnt++; if (video !== exp_v) $display("FAIL bl_video beat %0d got %h exp %h", b, video, exp_v); else pass_cnt++;
      chk_cnt++; if (src_ready !== 4'b0010) $display("FAIL bl_ready beat %0d got %b exp 0010", b, src_ready); else pass_cnt++;
      step();
    end
  endtask

  initial begin
    src_video4 = {S3, S2, S1, S0};
    src_video3 = {S2, S1, S0};
    test_reset();
    test_first_frame();
    test_manual_switch();
    test_cancel();
    test_last_beat_request();
    test_invalid_sel();
    test_auto_cycle();
    test_blank();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/video_source_sequencer.md
Name: video_source_sequencer

Overview:
- Shares one display output between NUM_SRC 24-bit pattern/video sources (pattern generators, frame readers).
- Tracks beat/line position from the sink's VideoReady and forwards VideoReady only to the active source.
- Muxes the active source's pixel onto the output.
- Switches sources (manual request or auto-cycle) only at frame boundaries; pulses a per-source restart so the new source begins at its frame origin.

Parameters:
- NUM_SRC, 4, number of sources (2..4); select width fixed at 2 bits.
- H_WORDS, 80, beats per line.
- V_LINES, 500, lines per frame.
- FRAMES_PER_SRC, 8, completed frames per source in auto-cycle mode (>=1).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- VideoReady  in  1  sink accepts a beat this cycle.
- SrcVideo  in  24*NUM_SRC  source pixels; source i at bits [24*i+23:24*i].
- SrcReady  out  NUM_SRC  per-source advance strobe.
- SrcRestart  out  NUM_SRC  one-cycle pulse: source restarts at frame origin.
- video  out  24  output pixel.
- SelReq  in  2  requested source index.
- SelReqValid  in  1  single-cycle request strobe.
- AutoCycle  in  1  enable automatic rotation.
- ActiveSrc  out  2  currently selected source.
- SwitchPending  out  1  manual request waiting for frame end.
- FrameDone  out  1  registered pulse, one cycle after the last beat of each frame.

Behaviour:
- Beat: any cycle with VideoReady=1.
- h_cnt counts 0..H_WORDS-1 per beat; on wrap, v_cnt counts 0..V_LINES-1.
- Last beat: h_cnt=H_WORDS-1 and v_cnt=V_LINES-1 and VideoReady. On the last beat both counters return to 0.
- Counters hold when VideoReady=0.
- Combinational, zero latency:
  - video = SrcVideo[ActiveSrc].
  - SrcReady = VideoReady in bit ActiveSrc only; all other bits 0.
- Reset values:
  - ActiveSrc=0, SwitchPending=0, pend_sel=0, h_cnt=v_cnt=0, frame counter=0.
  - SrcRestart=0, FrameDone=0.
- Reset mid-frame aborts any pending switch. Sources are reset by the global Reset.
- State machine:
  - RUN: on SelReqValid, with SelReq<NUM_SRC and SelReq!=ActiveSrc, latch pend_sel and go to PEND.
  - PEND: SwitchPending=1.
    - SelReqValid with a different valid index overwrites pend_sel.
    - SelReq==ActiveSrc cancels and returns to RUN.
    - On the last beat: next cycle ActiveSrc<=pend_sel, SrcRestart[pend_sel]=1 for one cycle, return to RUN.
- SelReq>=NUM_SRC is ignored in every state.
- Simultaneous request and last beat:
  - A request strobed on the last-beat cycle is not applied at that boundary.
  - It is latched, and applies at the end of the following frame.
  - A pending request that was already latched still switches at this boundary.
- Auto-cycle:
  - While AutoCycle=1, the frame counter increments on each last beat.
  - When it reaches FRAMES_PER_SRC on a last beat in RUN, ActiveSrc<=(ActiveSrc+1) mod NUM_SRC and SrcRestart pulses for the new source.
  - In PEND, the manual switch wins and auto advance is skipped.
  - Any switch clears the frame counter. AutoCycle=0 holds it at 0.
- FrameDone is asserted in the cycle after every last beat, including switch cycles.

Optional Feature:
- Macro: VIDEO_SWITCH_BLANK_EN.
- Defined:
  - During line 0 of the first frame after any switch, video=24'h000000.
  - SrcReady still strobes, so source alignment is unchanged.
  - Blanking ends when v_cnt leaves 0.
- Undefined: no blanking; video is always the active source's pixel.

Test Plan:
- Bench parameters for all scenarios: H_WORDS=4, V_LINES=3 (12 beats/frame), NUM_SRC=4, FRAMES_PER_SRC=2.
- After Reset, drive VideoReady=1 for 12 beats with SrcVideo0=24'h1ABC9C.
  - video=24'h1ABC9C and SrcReady=4'b0001 every beat.
  - FrameDone pulses once, cycle 13.
  - ActiveSrc=0.
- SelReqValid with SelReq=2 at beat 3.
  - SwitchPending=1 until the frame ends.
  - Cycle after beat 12: ActiveSrc=2, SrcRestart=4'b0100 for one cycle.
  - Next beats: SrcReady=4'b0100, video=SrcVideo2.
- Request SelReq=2 at beat 3, then SelReq=0 (ActiveSrc) at beat 6.
  - SwitchPending drops after beat 6; no switch at frame end.
- Request SelReq=1 exactly on the last-beat cycle.
  - ActiveSrc stays 0 through the next frame.
  - Switches after the following last beat.
- Request SelReq=3 with NUM_SRC=3.
  - Ignored; SwitchPending stays 0.
- AutoCycle=1 with continuous VideoReady.
  - ActiveSrc sequence 0,1,2,3,0, changing every 24 beats.
  - VideoReady toggling 1/0 doubles that interval; counters freeze on 0 cycles.
- With VIDEO_SWITCH_BLANK_EN defined, switch to source 1.
  - First 4 beats after the switch output 0.
  - Beat 5 onward outputs SrcVideo1.
